// File: rtl/calc_disp_pkg.sv
// Shared definitions for the calculator port dispatcher: routing modes,
// response codes and default sizing.
package calc_disp_pkg;

    localparam int ENV_CMD_SIZE   = 8;
    localparam int ENV_DATA_SIZE  = 16;
    localparam int DEF_NUM_PORTS  = 4;
    localparam int DEF_TAG_W      = 2;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        BROADCAST   = 2'd0,
        SINGLE      = 2'd1,
        ROUND_ROBIN = 2'd2,
        MODE_RSVD   = 2'd3
    } route_mode_e;

    // Any nonzero response code marks a completion of the tagged request
    localparam logic [1:0] RESP_NONE  = 2'd0;
    localparam logic [1:0] RESP_OK    = 2'd1;
    localparam logic [1:0] RESP_ERR   = 2'd2;
    localparam logic [1:0] RESP_RETRY = 2'd3;

    // The reserved mode code routes exactly like SINGLE
    function automatic route_mode_e effective_mode(input logic [1:0] raw);
        if (raw == 2'd3) begin
            return SINGLE;
        end
        return route_mode_e'(raw);
    endfunction

endpackage

// File: rtl/calc_cmd_fifo.sv
// Synchronous command buffer with full/empty flags; pushes while full and
// pops while empty are ignored.
module calc_cmd_fifo
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Pointer update; the extra wrap bit distinguishes full from empty
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/calc_port_dispatcher.sv
// Routes buffered calculator commands to DUT ports, allocating per-port tags
// and retiring them on completion responses.
module calc_port_dispatcher
    import calc_disp_pkg::*;
#(
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int CMD_W      = ENV_CMD_SIZE,
    parameter int DATA_W     = ENV_DATA_SIZE,
    parameter int TAG_W      = DEF_TAG_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int PORT_W    = $clog2(NUM_PORTS),
    localparam int NTAGS     = 1 << TAG_W,
    localparam int OUT_W     = $clog2(NUM_PORTS * NTAGS) + 1
)
(
    input  logic                        PClk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CMD_W-1:0]            in_cmd,
    input  logic [DATA_W-1:0]           in_data,
    input  logic [1:0]                  in_mode,
    input  logic [PORT_W-1:0]           in_port,
    output logic [NUM_PORTS*CMD_W-1:0]  req_cmd,
    output logic [NUM_PORTS*DATA_W-1:0] req_data,
    output logic [NUM_PORTS*TAG_W-1:0]  req_tag,
    input  logic [NUM_PORTS*2-1:0]      out_resp,
    input  logic [NUM_PORTS*TAG_W-1:0]  out_tag,
    output logic [OUT_W-1:0]            outstanding,
    output logic                        err_spurious
);

    localparam int ENTRY_W = CMD_W + DATA_W + 2 + PORT_W;

    logic [NUM_PORTS-1:0][NTAGS-1:0] busy;
    logic [NUM_PORTS-1:0][NTAGS-1:0] busy_next;
    logic [PORT_W-1:0]               rr_ptr;
    logic                            ready_en;
    logic                            fifo_full;
    logic                            fifo_empty;
    logic                            push_en;
    logic [ENTRY_W-1:0]              head_entry;
    logic [1:0]                      head_mode_raw;
    logic [PORT_W-1:0]               head_port;
    logic [CMD_W-1:0]                head_cmd;
    logic [DATA_W-1:0]               head_data;
    route_mode_e                     head_mode;
    logic [PORT_W-1:0]               target_port;
    logic                            broadcast;
    logic [NTAGS-1:0]                pick_free;
    logic [TAG_W-1:0]                alloc_tag;
    logic                            can_dispatch;
    logic                            spurious_hit;
    logic [NUM_PORTS*CMD_W-1:0]      req_cmd_next;
    logic [NUM_PORTS*DATA_W-1:0]     req_data_next;
    logic [NUM_PORTS*TAG_W-1:0]      req_tag_next;
    logic [OUT_W-1:0]                outstanding_next;

    // Zero commands are swallowed at the input and never occupy a slot
    assign in_ready = ready_en && !fifo_full;
    assign push_en  = in_valid && in_ready && (in_cmd != '0);

    calc_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (PClk),
        .reset (reset),
        .push  (push_en),
        .pop   (can_dispatch),
        .wdata ({in_mode, in_port, in_cmd, in_data}),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign {head_mode_raw, head_port, head_cmd, head_data} = head_entry;
    assign head_mode = effective_mode(head_mode_raw);

    // Pick the head's target and the lowest tag it can use; out-of-range
    // port numbers fold onto the last port
    always_comb begin
        target_port = '0;
        broadcast   = 1'b0;
        alloc_tag   = '0;
        pick_free   = '1;
        case (head_mode)
            BROADCAST:   broadcast   = 1'b1;
            ROUND_ROBIN: target_port = rr_ptr;
            default:     target_port = (head_port > PORT_W'(NUM_PORTS - 1)) ?
                                       PORT_W'(NUM_PORTS - 1) : head_port;
        endcase
        if (broadcast) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                pick_free = pick_free & ~busy[p];
            end
        end else begin
            pick_free = ~busy[target_port];
        end
        for (int t = NTAGS - 1; t >= 0; t--) begin
            if (pick_free[t]) alloc_tag = TAG_W'(t);
        end
        can_dispatch = !fifo_empty && (|pick_free);
    end

    // Retire completions, claim the dispatched tag and form the request drive
    always_comb begin
        busy_next        = busy;
        spurious_hit     = 1'b0;
        req_cmd_next     = '0;
        req_data_next    = '0;
        req_tag_next     = '0;
        outstanding_next = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (out_resp[p*2 +: 2] != RESP_NONE) begin
                if (busy[p][out_tag[p*TAG_W +: TAG_W]]) begin
                    busy_next[p][out_tag[p*TAG_W +: TAG_W]] = 1'b0;
                end else begin
                    spurious_hit = 1'b1;
                end
            end
        end
        if (can_dispatch) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (broadcast || (target_port == PORT_W'(p))) begin
                    busy_next[p][alloc_tag]           = 1'b1;
                    req_cmd_next[p*CMD_W +: CMD_W]    = head_cmd;
                    req_data_next[p*DATA_W +: DATA_W] = head_data;
                    req_tag_next[p*TAG_W +: TAG_W]    = alloc_tag;
                end
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int t = 0; t < NTAGS; t++) begin
                outstanding_next = outstanding_next + OUT_W'(busy_next[p][t]);
            end
        end
    end

    // Tag state, round-robin pointer and registered outputs
    always_ff @(posedge PClk) begin
        if (!reset) begin
            busy         <= '0;
            rr_ptr       <= '0;
            req_cmd      <= '0;
            req_data     <= '0;
            req_tag      <= '0;
            outstanding  <= '0;
            err_spurious <= 1'b0;
            ready_en     <= 1'b0;
        end else begin
            busy        <= busy_next;
            req_cmd     <= req_cmd_next;
            req_data    <= req_data_next;
            req_tag     <= req_tag_next;
            outstanding <= outstanding_next;
            ready_en    <= 1'b1;
            if (spurious_hit) err_spurious <= 1'b1;
            if (can_dispatch && (head_mode == ROUND_ROBIN)) begin
                rr_ptr <= (rr_ptr == PORT_W'(NUM_PORTS - 1)) ? '0 : rr_ptr + PORT_W'(1);
            end
        end
    end

endmodule
